// File: rtl/parity_frame_checker.sv
// Receive-side parity checker with registered output, all-ones/all-zeros
// flags, a saturating error counter and a fault lock after a run of
// consecutive parity errors. Valid/ready handshake on both sides.
module parity_frame_checker #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             out_all1,
    output logic             out_all0,
    output logic [CNT_W-1:0] err_count,
    input  logic             clr_count,
    output logic             fault
);

    localparam int CONS_W = $clog2(ERR_LIMIT + 1);
    localparam logic [CONS_W-1:0] LIMIT = CONS_W'(ERR_LIMIT);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t state, state_next;

    logic              accept;
    logic              word_err;
    logic [CNT_W-1:0]  err_count_next;
    logic [CONS_W-1:0] cons_count, cons_next;

    assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign word_err = (^in_data) ^ in_par ^ odd_mode;
    assign fault    = (state == ST_FAULT);

    // Counter updates: a clear takes effect first, then the accepted word is counted
    always_comb begin
        err_count_next = clr_count ? '0 : err_count;
        cons_next      = clr_count ? '0 : cons_count;
        if (accept) begin
            if (word_err) begin
                if (err_count_next != {CNT_W{1'b1}}) begin
                    err_count_next = err_count_next + CNT_W'(1);
                end
                cons_next = cons_next + CONS_W'(1);
            end else begin
                cons_next = '0;
            end
        end
    end

    // Next-state logic: lock on the word that completes the error run, unlock on clear
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (accept && word_err && (cons_next == LIMIT)) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (clr_count) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            err_count  <= '0;
            cons_count <= '0;
        end else begin
            state      <= state_next;
            err_count  <= err_count_next;
            cons_count <= cons_next;
        end
    end

    // Output register: load on accept, hold under backpressure, empty once drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_all1  <= 1'b0;
            out_all0  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_err   <= word_err;
            out_all1  <= &in_data;
            out_all0  <= ~|in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: stimulus pushes expected words,
// a monitor pops and compares whenever the DUT hands a word downstream.
module tb_parity_frame_checker;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       all1;
        logic       all0;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_par;
    logic       odd_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic       out_all1;
    logic       out_all0;
    logic [7:0] err_count;
    logic       clr_count;
    logic       fault;

    logic       s_in_valid;
    logic       s_in_ready;
    logic [7:0] s_in_data;
    logic       s_out_valid;
    logic [7:0] s_out_data;
    logic       s_out_err;
    logic       s_out_all1;
    logic       s_out_all0;
    logic [1:0] s_err_count;
    logic       s_fault;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    parity_frame_checker #(.WIDTH(8), .CNT_W(8), .ERR_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_par(in_par), .odd_mode(odd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .out_all1(out_all1), .out_all0(out_all0),
        .err_count(err_count), .clr_count(clr_count), .fault(fault)
    );

    parity_frame_checker #(.WIDTH(8), .CNT_W(2), .ERR_LIMIT(255)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .in_par(1'b0), .odd_mode(1'b0),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
        .out_err(s_out_err), .out_all1(s_out_all1), .out_all0(s_out_all0),
        .err_count(s_err_count), .clr_count(1'b0), .fault(s_fault)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Offer one word (called on a falling edge); returns on the falling edge after acceptance
    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic om,
                                 input logic e_err, input logic e_all1, input logic e_all0);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_par   = p;
        odd_mode = om;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back('{data: d, err: e_err, all1: e_all1, all0: e_all0});
                done = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted data=%0h", d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulseClear();
        clr_count = 1'b1;
        @(negedge clk);
        clr_count = 1'b0;
    endtask

    // Monitor: every word handed downstream must match the head of the expected queue
    initial begin
        exp_t got;
        exp_t want;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                got = '{data: out_data, err: out_err, all1: out_all1, all0: out_all0};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_extra actual=%0h required=no_word", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("[TB] FAIL scoreboard_word actual=%0h required=%0h", got, want);
                    end
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_par     = 1'b0;
        odd_mode   = 1'b0;
        out_ready  = 1'b1;
        clr_count  = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_flags", {out_err, out_all1, out_all0}, 0);
        checkOutput("reset_err_count", err_count, 0);
        checkOutput("reset_fault", fault, 0);
        @(negedge clk);
        rst = 1'b0;

        // Saturation on the narrow-counter instance: 5 bad words, counter stops at 3
        s_in_data  = 8'h01;
        s_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("sat_err_count", s_err_count, (i < 3) ? i + 1 : 3);
            checkOutput("sat_out", {s_in_ready, s_out_valid, s_out_data, s_out_err,
                                    s_out_all1, s_out_all0, s_fault}, {2'b11, 8'h01, 4'b1000});
        end
        s_in_valid = 1'b0;
        @(negedge clk);

        // Basic words, parity mode changing per word
        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("a5_err_count", err_count, 0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 checkOutput("ff_err_count", err_count, 1);
        applyStimulus(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("00_err_count", err_count, 1);
        @(negedge clk);

        // Backpressure: first word held, second word stalled until out_ready returns
        out_ready = 1'b0;
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_data  = 8'h81;
        in_par   = 1'b0;
        odd_mode = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("stall_in_ready", in_ready, 0);
            checkOutput("stall_out_data", {out_valid, out_data}, {1'b1, 8'h3C});
            @(negedge clk);
        end
        out_ready = 1'b1;
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Four consecutive bad words lock the checker
        pulseClear();
        #1 checkOutput("clear_err_count", err_count, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput("run_fault", fault, (i == 3) ? 1 : 0);
            checkOutput("run_err_count", err_count, i + 1);
        end
        checkOutput("fault_in_ready", in_ready, 0);
        in_data  = 8'h01;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 checkOutput("fault_blocked_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        pulseClear();
        #1;
        checkOutput("unlock_fault", fault, 0);
        checkOutput("unlock_err_count", err_count, 0);
        checkOutput("unlock_in_ready", in_ready, 1);

        // Clear coinciding with a bad word: clear first, then count it
        @(negedge clk);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        clr_count = 1'b1;
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        clr_count = 1'b0;
        #1 checkOutput("clr_and_err_count", err_count, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1 checkOutput("after_clr_fault", fault, (i == 2) ? 1 : 0);
        end
        checkOutput("after_clr_err_count", err_count, 4);
        pulseClear();

        // Odd mode clean word
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while a word is held and err_count is 2
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        checkOutput("pre_reset_state", {out_valid, err_count}, {1'b1, 8'd2});
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_out", {out_valid, out_data, out_err, out_all1, out_all0}, 0);
        checkOutput("async_reset_err_count", err_count, 0);
        checkOutput("async_reset_fault", fault, 0);
        @(negedge clk);
        exp_q.delete();
        rst       = 1'b0;
        out_ready = 1'b1;
        applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("post_reset_err_count", err_count, 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Receive-side counterpart of the parity/reduction generator logic: accepts data words carrying a parity bit and checks parity in even or odd mode.
- Flags all-ones and all-zeros words.
- Counts errors and locks the input into a fault state after a run of consecutive parity errors.
- Sits between a parity-protected link and downstream consumers, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, data word width in bits (≥2)
- CNT_W, 8, width of the saturating error counter
- ERR_LIMIT, 4, number of consecutive parity errors that forces the FAULT state (1..255)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  checker can accept a word this cycle
- in_data  input  WIDTH  received data word
- in_par  input  1  received parity bit
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with each accepted word
- out_valid  output  1  checked word held in output register
- out_ready  input  1  downstream accepts the output word
- out_data  output  WIDTH  registered copy of in_data
- out_err  output  1  parity mismatch for out_data
- out_all1  output  1  reduction-AND of out_data
- out_all0  output  1  NOR-reduction of out_data
- err_count  output  CNT_W  total parity errors accepted, saturating
- clr_count  input  1  synchronous clear of err_count and fault
- fault  output  1  high while in FAULT state

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_err=0, out_all1=0, out_all0=0, err_count=0, consecutive-error counter=0, state=RUN, fault=0. Reset mid-transfer discards the held word.
- Accept condition: in_valid && in_ready.
- in_ready = (state==RUN) && (!out_valid || out_ready). This is combinational and gives full throughput of one word per cycle.
- Latency: an accepted word appears on the out_* ports on the next rising edge, with out_valid=1.
- The output register holds its value while out_valid && !out_ready.
- out_valid clears on out_ready unless a new word is accepted the same cycle.
- Parity error rule: err = (^in_data) ^ in_par ^ odd_mode.
  - Even mode: the total count of ones across data and parity must be even.
  - Odd mode: that total must be odd.
- out_all1 = &in_data and out_all0 = ~|in_data, both registered with the word. If out_err=1, the flags still reflect the data as received.
- err_count: +1 per accepted word with err=1. It saturates at 2^CNT_W−1 and never wraps.
- Consecutive-error counter (width ≥ log2(ERR_LIMIT)+1):
  - +1 on an accepted erroneous word.
  - Reset to 0 on an accepted clean word.
  - Unchanged on cycles with no accept.
- FSM:
  - RUN → FAULT on the edge where an accepted erroneous word brings the consecutive count to ERR_LIMIT. That word itself is still accepted and output.
  - FAULT: in_ready=0 and fault=1. The output register still drains normally.
  - FAULT → RUN on clr_count=1. The consecutive count resets to 0.
- clr_count effects:
  - Zeroes err_count.
  - Zeroes the consecutive count.
  - In FAULT, returns to RUN; in_ready may go high from the following cycle.
- Simultaneous clr_count and an accepted erroneous word: err_count=1 and consecutive count=1; the clear applies first, then the increment.
- odd_mode may change between words; each word uses the value sampled at its own accept.

Test Plan:
- Even mode, in_data=8'hA5, in_par=0 → one cycle later out_data=A5, out_err=0, out_all1=0, out_all0=0, err_count=0.
- Odd mode, in_data=8'hFF, in_par=0 → out_err=1, out_all1=1, err_count=1; next word 8'h00, in_par=1 → out_err=0, out_all0=1.
- Backpressure: out_ready=0 after the first word → in_ready=0 and out_data stays stable for 5 cycles. Then raise out_ready with in_valid held → the second word appears on the next edge, with no loss or duplication.
- Four consecutive bad words (even mode, 8'h01, in_par=0) → the fourth is output with out_err=1, fault=1 and in_ready=0 on the following cycle, err_count=4. Pulse clr_count → fault=0, err_count=0, in_ready=1.
- Saturation: CNT_W=2, ERR_LIMIT=255, 5 bad words → err_count stays at 3.
- Assert rst while out_valid=1 and err_count=2 → all outputs are 0 immediately, without waiting for a clock edge.
